ex_mem_wb_pipeline: RTL and testbench

//  EX/MEM and MEM/WB pipeline registers plus MEM-stage data-memory handshake for the 5-stage MIPS core.

---
 rtl/ex_mem_wb_pipeline.sv | 213 +++++++++++++++++++++
 tb/tb_ex_mem_wb_pipeline.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_wb_pipeline.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_wb_pipeline
//  Description : EX/MEM and MEM/WB pipeline registers with the MEM-stage
//                data-memory handshake for a 5-stage MIPS core. Feeds the
//                forwarding unit with MEM/WB destinations, write enables and
//                forwardable data, and raises stall_mem while an access is
//                outstanding.
//  Ports       : clk, rst                      clock / sync active-high reset
//                ex_*                          EX-stage instruction fields
//                mem_req/we/addr/wdata/rdata/ack  data-memory handshake
//                stall_mem                     freeze IF/ID/EX
//                rd_mem, reg_write_mem, alu_result_mem   MEM-stage outputs
//                rd_wb, reg_write_wb, wb_data  WB-stage outputs
//                mem_err                       sticky access-timeout flag
//                perf_retired, perf_stall      (PIPE_PERF_CNT_EN only)
//  Options     : `define PIPE_PERF_CNT_EN adds retired/stall counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_wb_pipeline #(
    parameter int DATA_W      = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_mem,
    output logic [4:0]        rd_mem,
    output logic              reg_write_mem,
    output logic [DATA_W-1:0] alu_result_mem,
    output logic [4:0]        rd_wb,
    output logic              reg_write_wb,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_err
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]       perf_retired,
    output logic [31:0]       perf_stall
`endif
);

    // Counter value on the last permitted WAIT cycle (counter is 0 on the
    // first WAIT cycle).
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_wait_cnt, w_wait_cnt_nxt;

    // MEM stage
    logic              r_mem_valid;
    logic [4:0]        r_mem_rd;
    logic              r_mem_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [DATA_W-1:0] r_mem_alu;
    logic [DATA_W-1:0] r_mem_wdata;

    // WB stage
    logic              r_wb_valid;
    logic              r_wb_reg_write;
    logic [4:0]        r_wb_rd;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_mem_err;

    logic              w_mem_op;
    logic              w_to_hit;
    logic              w_stall;
    logic [DATA_W-1:0] w_load_data;

    always_comb begin
        w_mem_op    = r_mem_valid & (r_mem_read | r_mem_write);
        w_to_hit    = (r_state == S_WAIT) && (r_wait_cnt == c_TIMEOUT_LAST);
        // An ack arriving on the timeout cycle wins: the stall still drops,
        // but the access is treated as a normal completion.
        w_stall     = w_mem_op & ~mem_ack & ~w_to_hit;
        // Timed-out loads deliver zero.
        w_load_data = mem_ack ? mem_rdata : '0;
    end

    // Access FSM: next-state
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            S_RUN: begin
                w_wait_cnt_nxt = 8'd0;
                if (w_mem_op && !mem_ack) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_ack || w_to_hit) begin
                    w_state_nxt    = S_RUN;
                    w_wait_cnt_nxt = 8'd0;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt    = S_RUN;
                w_wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // EX -> MEM. Control bits are qualified by ex_valid so a bubble can never
    // start a memory access; a store never writes the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_valid     <= 1'b0;
            r_mem_rd        <= 5'd0;
            r_mem_reg_write <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_alu       <= '0;
            r_mem_wdata     <= '0;
        end else if (!w_stall) begin
            r_mem_valid     <= ex_valid;
            r_mem_rd        <= ex_rd;
            r_mem_reg_write <= ex_valid & ex_reg_write & ~ex_mem_write;
            r_mem_read      <= ex_valid & ex_mem_read;
            r_mem_write     <= ex_valid & ex_mem_write;
            r_mem_alu       <= ex_alu_result;
            r_mem_wdata     <= ex_store_data;
        end
    end

    // MEM -> WB. A stalled MEM stage sends a bubble so the instruction reaches
    // WB exactly once, on the cycle its access completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_rd        <= 5'd0;
            r_wb_data      <= '0;
            r_mem_err      <= 1'b0;
        end else begin
            r_wb_valid     <= r_mem_valid & ~w_stall;
            r_wb_reg_write <= r_mem_reg_write;
            if (!w_stall) begin
                r_wb_rd   <= r_mem_rd;
                r_wb_data <= r_mem_read ? w_load_data : r_mem_alu;
            end
            if (w_mem_op && w_to_hit && !mem_ack) begin
                r_mem_err <= 1'b1;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_perf_retired;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_retired <= 32'd0;
            r_perf_stall   <= 32'd0;
        end else begin
            if (r_wb_valid) begin
                r_perf_retired <= r_perf_retired + 32'd1;
            end
            if (w_stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_retired = r_perf_retired;
    assign perf_stall   = r_perf_stall;
`endif

    assign mem_req        = w_mem_op;
    assign mem_we         = r_mem_write;
    assign mem_addr       = r_mem_alu;
    assign mem_wdata      = r_mem_wdata;
    assign stall_mem      = w_stall;
    assign rd_mem         = r_mem_rd;
    assign reg_write_mem  = r_mem_valid & r_mem_reg_write;
    assign alu_result_mem = r_mem_alu;
    assign rd_wb          = r_wb_rd;
    assign reg_write_wb   = r_wb_valid & r_wb_reg_write;
    assign wb_data        = r_wb_data;
    assign mem_err        = r_mem_err;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_wb_pipeline.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_mem_wb_pipeline
//  Description : Self-checking bench for ex_mem_wb_pipeline: directed vector
//                table, reset/bubble sequences and random traffic against a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_wb_pipeline;

    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ex_valid = 1'b0, ex_reg_write = 1'b0;
    logic          ex_mem_read = 1'b0, ex_mem_write = 1'b0;
    logic [4:0]    ex_rd = 5'd0;
    logic [DW-1:0] ex_alu_result = '0, ex_store_data = '0;
    logic          mem_req, mem_we, mem_ack = 1'b0, stall_mem;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [4:0]    rd_mem, rd_wb;
    logic          reg_write_mem, reg_write_wb, mem_err;
    logic [DW-1:0] alu_result_mem, wb_data;

    ex_mem_wb_pipeline #(.DATA_W(DW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_mem(stall_mem), .rd_mem(rd_mem), .reg_write_mem(reg_write_mem),
        .alu_result_mem(alu_result_mem), .rd_wb(rd_wb),
        .reg_write_wb(reg_write_wb), .wb_data(wb_data), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // An instruction plus the memory's behaviour for it: lat = cycles from the
    // first MEM cycle to mem_ack (1 = same cycle), 0 = never acknowledged.
    typedef struct {
        bit          v;
        logic [4:0]  rd;
        bit          rw, mr, mw;
        logic [31:0] alu, sd, rdata;
        int          lat;
    } instr_t;

    typedef struct {
        instr_t      ins;
        int          exp_stalls;
        bit          exp_rw_wb;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        bit          exp_err;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the instruction in MEM, how long its access has been
    // outstanding, and what WB currently holds.
    instr_t      ex_cur, m_mem;
    int          m_waited;
    bit          m_wb_v, m_wb_rw, m_err;
    logic [4:0]  m_wb_rd;
    logic [31:0] m_wb_data;

    // Observations from the most recent step
    bit          obs_stall, obs_req, obs_rw_mem, obs_rw_wb, obs_err;
    logic [4:0]  obs_rd_wb;
    logic [31:0] obs_wb_data;

    function automatic instr_t bubble();
        instr_t b;
        b.v = 0; b.rd = '0; b.rw = 0; b.mr = 0; b.mw = 0;
        b.alu = '0; b.sd = '0; b.rdata = '0; b.lat = 1;
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs, advance the model.
    task automatic step();
        bit          op, ack, tmo, stall;
        op  = m_mem.v && (m_mem.mr || m_mem.mw);
        ack = op && (m_mem.lat != 0) && (m_waited == m_mem.lat - 1);
        tmo = op && !ack && (m_waited == TO);
        stall = op && !ack && !tmo;

        mem_ack       = ack;
        mem_rdata     = ack ? m_mem.rdata : $urandom();
        ex_valid      = ex_cur.v;
        ex_rd         = ex_cur.rd;
        ex_reg_write  = ex_cur.rw;
        ex_mem_read   = ex_cur.mr;
        ex_mem_write  = ex_cur.mw;
        ex_alu_result = ex_cur.alu;
        ex_store_data = ex_cur.sd;
        #1;

        chk("stall_mem", 32'(stall_mem), 32'(stall));
        chk("mem_req", 32'(mem_req), 32'(op));
        chk("reg_write_mem", 32'(reg_write_mem), 32'(m_mem.v && m_mem.rw && !m_mem.mw));
        chk("reg_write_wb", 32'(reg_write_wb), 32'(m_wb_v && m_wb_rw));
        chk("mem_err", 32'(mem_err), 32'(m_err));
        if (op) begin
            chk("mem_we", 32'(mem_we), 32'(m_mem.mw));
            chk("mem_addr", mem_addr, m_mem.alu);
            if (m_mem.mw) chk("mem_wdata", mem_wdata, m_mem.sd);
        end
        if (m_mem.v) begin
            chk("rd_mem", 32'(rd_mem), 32'(m_mem.rd));
            chk("alu_result_mem", alu_result_mem, m_mem.alu);
        end
        if (m_wb_v) begin
            chk("rd_wb", 32'(rd_wb), 32'(m_wb_rd));
            chk("wb_data", wb_data, m_wb_data);
        end

        obs_stall = stall_mem; obs_req = mem_req; obs_rw_mem = reg_write_mem;
        obs_rw_wb = reg_write_wb; obs_err = mem_err;
        obs_rd_wb = rd_wb; obs_wb_data = wb_data;

        if (rst) begin
            m_mem = bubble(); m_waited = 0; m_wb_v = 0; m_wb_rw = 0; m_err = 0;
        end else begin
            if (tmo) m_err = 1;
            m_wb_v  = m_mem.v && !stall;
            m_wb_rw = m_mem.rw && !m_mem.mw;
            if (!stall) begin
                m_wb_rd   = m_mem.rd;
                m_wb_data = m_mem.mr ? (ack ? m_mem.rdata : 32'd0) : m_mem.alu;
                m_mem     = ex_cur;
                m_waited  = 0;
            end else begin
                m_waited++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ex_cur = bubble();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  stalls;
        bit  done;
        do_reset();
        ex_cur = v.ins;
        step();
        ex_cur = bubble();
        stalls = 0;
        done = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (!obs_stall) begin
                done = 1;
                break;
            end
            stalls++;
        end
        chk($sformatf("vec%0d completes within budget", idx), 32'(done), 32'd1);
        step();
        chk($sformatf("vec%0d stall cycles", idx), 32'(stalls), 32'(v.exp_stalls));
        chk($sformatf("vec%0d reg_write_wb", idx), 32'(obs_rw_wb), 32'(v.exp_rw_wb));
        chk($sformatf("vec%0d rd_wb", idx), 32'(obs_rd_wb), 32'(v.exp_rd));
        chk($sformatf("vec%0d wb_data", idx), obs_wb_data, v.exp_data);
        chk($sformatf("vec%0d mem_err", idx), 32'(obs_err), 32'(v.exp_err));
    endtask

    function automatic instr_t mk(bit mr, bit mw, bit rw, logic [4:0] rd,
                                  logic [31:0] alu, logic [31:0] sd,
                                  logic [31:0] rdata, int lat);
        instr_t i;
        i.v = 1; i.mr = mr; i.mw = mw; i.rw = rw; i.rd = rd;
        i.alu = alu; i.sd = sd; i.rdata = rdata; i.lat = lat;
        return i;
    endfunction

    initial begin
        vec_t vecs[8];
        int   req_seen;

        // ins, stalls, rw_wb, rd_wb, wb_data, err
        vecs[0] = '{mk(0,0,1,5'd5,32'h1234,32'h0,32'h0,1), 0, 1, 5'd5, 32'h1234, 0};
        vecs[1] = '{mk(1,0,1,5'd7,32'h40,32'h0,32'hCAFEF00D,3), 2, 1, 5'd7, 32'hCAFEF00D, 0};
        vecs[2] = '{mk(0,1,1,5'd9,32'h80,32'hAA,32'h0,1), 0, 0, 5'd9, 32'h80, 0};
        vecs[3] = '{mk(1,0,1,5'd3,32'h44,32'h0,32'h12345678,0), TO, 1, 5'd3, 32'h0, 1};
        vecs[4] = '{mk(1,0,1,5'd0,32'h48,32'h0,32'h55AA55AA,1), 0, 1, 5'd0, 32'h55AA55AA, 0};
        vecs[5] = '{mk(1,0,1,5'd4,32'h4C,32'h0,32'hDEADBEEF,TO+1), TO, 1, 5'd4, 32'hDEADBEEF, 0};
        vecs[6] = '{mk(1,0,1,5'd6,32'h50,32'h0,32'h0BADF00D,TO), TO-1, 1, 5'd6, 32'h0BADF00D, 0};
        vecs[7] = '{mk(0,1,0,5'd8,32'h84,32'h77,32'h0,4), 3, 0, 5'd8, 32'h84, 0};

        // Power-up: hold reset without checking, then the model starts clean.
        ex_cur = bubble(); m_mem = bubble(); m_waited = 0;
        m_wb_v = 0; m_wb_rw = 0; m_err = 0; m_wb_rd = '0; m_wb_data = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("reset mem_req", 32'(obs_req), 32'd0);
        chk("reset reg_write_wb", 32'(obs_rw_wb), 32'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset while waiting on the memory abandons the access.
        do_reset();
        ex_cur = mk(1,0,1,5'd2,32'h60,32'h0,32'h1,0);
        step();
        ex_cur = bubble();
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("rst-in-wait mem_req", 32'(obs_req), 32'd0);
        chk("rst-in-wait stall_mem", 32'(obs_stall), 32'd0);
        chk("rst-in-wait reg_write_mem", 32'(obs_rw_mem), 32'd0);
        chk("rst-in-wait reg_write_wb", 32'(obs_rw_wb), 32'd0);
        chk("rst-in-wait mem_err", 32'(obs_err), 32'd0);

        // Back-to-back bubbles never request memory.
        ex_cur = bubble();
        ex_cur.mr = 1; ex_cur.rw = 1;   // control bits set but not valid
        req_seen = 0;
        repeat (6) begin
            step();
            if (obs_req || obs_rw_mem || obs_rw_wb) req_seen++;
        end
        chk("bubbles no activity", 32'(req_seen), 32'd0);

        // Random traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            int r;
            rst = ($urandom_range(0, 299) == 0);
            if (!obs_stall || rst) begin
                ex_cur.v     = ($urandom_range(0, 4) != 0);
                r            = $urandom_range(0, 2);
                ex_cur.mr    = (r == 1);
                ex_cur.mw    = (r == 2);
                ex_cur.rw    = (r == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
                ex_cur.rd    = 5'($urandom());
                ex_cur.alu   = $urandom();
                ex_cur.sd    = $urandom();
                ex_cur.rdata = $urandom();
                r = $urandom_range(0, 19);
                ex_cur.lat = (r == 0) ? 0 : (r == 1) ? TO + 1 : (r == 2) ? TO : 1 + (r % 4);
            end
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
